// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game sequencer and its surroundings: button/datapath
// inputs towards the controller, step strobe, move code and status back out.
interface snake_game_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic             btn_start;
    logic             game_over;
    logic             apple_eaten;
    logic             animate;
    logic [2:0]       move;
    logic             game_rst;
    logic [1:0]       state;
    logic [CNT_W-1:0] period;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_start, game_over, apple_eaten,
        input  animate, move, game_rst, state, period
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_start, game_over, apple_eaten,
        output animate, move, game_rst, state, period
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/RUN/PAUSE/OVER flow, step tick with apple-driven speed-up,
// and a direction filter that forbids 180-degree reversals.
module snake_game_ctrl #(
    parameter int unsigned START_PERIOD = 12_500_000,
    parameter int unsigned MIN_PERIOD   = 3_125_000,
    parameter int unsigned SPEED_STEP   = 500_000,
    parameter int unsigned OVER_HOLD    = 100_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input logic              clk,
    input logic              rst,
    snake_game_ctrl_if.slave bus
);
    localparam int unsigned      SubW        = CNT_W + 1;
    localparam logic [CNT_W-1:0] StartPeriod = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] MinPeriod   = CNT_W'(MIN_PERIOD);
    localparam logic [SubW-1:0]  SpeedStep   = SubW'(SPEED_STEP);
    localparam logic [CNT_W-1:0] HoldMax     = CNT_W'(OVER_HOLD - 1);
    localparam logic [CNT_W-1:0] One         = CNT_W'(1);

    localparam logic [2:0] DirRight = 3'b000;
    localparam logic [2:0] DirUp    = 3'b001;
    localparam logic [2:0] DirLeft  = 3'b010;
    localparam logic [2:0] DirDown  = 3'b011;
    localparam logic [2:0] MoveHold = 3'b100;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StOver  = 2'b11
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hold_q;
    logic [2:0]       dir_q;
    logic [2:0]       pend_q;
    logic [2:0]       move_q;
    logic             animate_q;
    logic             game_rst_q;

    logic             press_any;
    logic [2:0]       press_dir;
    logic             press_ok;
    logic [2:0]       pend_nxt;
    logic [SubW-1:0]  period_sub;
    logic [CNT_W-1:0] period_dec;
    logic             step_due;

    // Fixed priority among simultaneous presses; reversal check applies to the winner only.
    always_comb begin
        press_any = 1'b1;
        press_dir = DirRight;
        if (bus.btn_up) begin
            press_dir = DirUp;
        end else if (bus.btn_down) begin
            press_dir = DirDown;
        end else if (bus.btn_left) begin
            press_dir = DirLeft;
        end else if (!bus.btn_right) begin
            press_any = 1'b0;
        end
    end

    // Opposite directions differ only in bit 1 of the move encoding.
    assign press_ok = press_any && (press_dir != (dir_q ^ 3'b010));
    assign pend_nxt = press_ok ? press_dir : pend_q;

    // One extra bit so the subtraction cannot wrap below zero.
    assign period_sub = {1'b0, period_q} - SpeedStep;
    assign period_dec = (period_sub[CNT_W] || (period_sub[CNT_W-1:0] < MinPeriod)) ?
                        MinPeriod : period_sub[CNT_W-1:0];

    assign step_due = cnt_q >= (period_q - One);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            period_q   <= StartPeriod;
            cnt_q      <= '0;
            hold_q     <= '0;
            dir_q      <= DirRight;
            pend_q     <= DirRight;
            move_q     <= MoveHold;
            animate_q  <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            animate_q  <= 1'b0;
            game_rst_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    move_q <= MoveHold;
                    if (bus.btn_start) begin
                        state_q    <= StRun;
                        game_rst_q <= 1'b1;
                        period_q   <= StartPeriod;
                        cnt_q      <= '0;
                        dir_q      <= DirRight;
                        pend_q     <= DirRight;
                        move_q     <= DirRight;
                    end
                end
                StRun: begin
                    if (bus.game_over) begin
                        state_q <= StOver;
                        hold_q  <= '0;
                        move_q  <= MoveHold;
                    end else begin
                        pend_q <= pend_nxt;
                        if (bus.apple_eaten) begin
                            period_q <= period_dec;
                        end
                        if (bus.btn_start) begin
                            state_q <= StPause;
                            move_q  <= MoveHold;
                        end else if (step_due) begin
                            animate_q <= 1'b1;
                            cnt_q     <= '0;
                            dir_q     <= pend_nxt;
                            move_q    <= pend_nxt;
                        end else begin
                            cnt_q  <= cnt_q + One;
                            move_q <= dir_q;
                        end
                    end
                end
                StPause: begin
                    move_q <= MoveHold;
                    if (bus.game_over) begin
                        state_q <= StOver;
                        hold_q  <= '0;
                    end else if (bus.btn_start) begin
                        state_q <= StRun;
                        move_q  <= dir_q;
                    end
                end
                StOver: begin
                    move_q <= MoveHold;
                    if (hold_q >= HoldMax) begin
                        if (bus.btn_start) begin
                            state_q <= StIdle;
                            hold_q  <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + One;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.animate  = animate_q;
    assign bus.move     = move_q;
    assign bus.game_rst = game_rst_q;
    assign bus.state    = state_q;
    assign bus.period   = period_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: stimulus queues expected animate/game_rst pulses,
// a negedge monitor matches every pulse the DUT emits against the queue.
module tb_snake_game_ctrl;
    localparam int unsigned CW = 32;

    localparam int unsigned B_RIGHT = 1;
    localparam int unsigned B_LEFT  = 2;
    localparam int unsigned B_DOWN  = 4;
    localparam int unsigned B_UP    = 8;
    localparam int unsigned B_START = 16;
    localparam int unsigned B_APPLE = 32;

    typedef struct {
        int          cyc;
        bit          is_rst;
        logic [2:0]  move;
        logic [31:0] period;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    exp_t sb[$];
    exp_t e;

    int S, P, R, O, S2;

    snake_game_ctrl_if #(.CNT_W(CW)) bus ();

    snake_game_ctrl #(
        .START_PERIOD(10),
        .MIN_PERIOD  (4),
        .SPEED_STEP  (3),
        .OVER_HOLD   (5),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every pulse must match the head of the scoreboard; overdue entries are misses.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            ncmp++;
            nerr++;
            $display("FAIL missing_pulse: nothing at cycle %0d, expected %s move=%03b",
                     e.cyc, e.is_rst ? "game_rst" : "animate", e.move);
        end
        if (bus.animate || bus.game_rst) begin
            ncmp++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_pulse: cyc=%0d animate=%0b game_rst=%0b, expected none",
                         cyc, bus.animate, bus.game_rst);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || bus.game_rst != e.is_rst || bus.animate != !e.is_rst ||
                    bus.move != e.move || bus.period != e.period) begin
                    nerr++;
                    $display({"FAIL pulse: got cyc=%0d anim=%0b rst=%0b move=%03b period=%0d, ",
                              "expected cyc=%0d anim=%0b rst=%0b move=%03b period=%0d"},
                             cyc, bus.animate, bus.game_rst, bus.move, bus.period,
                             e.cyc, !e.is_rst, e.is_rst, e.move, e.period);
                end
            end
        end
    end

    function automatic void expect_ev(int c, bit r, logic [2:0] m, logic [31:0] p);
        exp_t x;
        x.cyc    = c;
        x.is_rst = r;
        x.move   = m;
        x.period = p;
        sb.push_back(x);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Present the buttons so they are sampled by clock edge t; returns at the negedge after it.
    task automatic drive_at(int t, int unsigned v);
        wait_cyc(t - 1);
        bus.btn_right   = v[0];
        bus.btn_left    = v[1];
        bus.btn_down    = v[2];
        bus.btn_up      = v[3];
        bus.btn_start   = v[4];
        bus.apple_eaten = v[5];
        @(negedge clk);
        bus.btn_right   = 1'b0;
        bus.btn_left    = 1'b0;
        bus.btn_down    = 1'b0;
        bus.btn_up      = 1'b0;
        bus.btn_start   = 1'b0;
        bus.apple_eaten = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.btn_up      = 1'b0;
        bus.btn_down    = 1'b0;
        bus.btn_left    = 1'b0;
        bus.btn_right   = 1'b0;
        bus.btn_start   = 1'b0;
        bus.game_over   = 1'b0;
        bus.apple_eaten = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_move", 32'(bus.move), 32'h4);
        chk("rst_animate", 32'(bus.animate), 0);
        chk("rst_game_rst", 32'(bus.game_rst), 0);
        chk("rst_period", bus.period, 10);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_state", 32'(bus.state), 0);

        // Start, then steps every 10 cycles; left is a reversal of right and is dropped.
        S = cyc + 1;
        expect_ev(S, 1'b1, 3'b000, 10);
        expect_ev(S + 10, 1'b0, 3'b000, 10);
        expect_ev(S + 20, 1'b0, 3'b000, 10);
        expect_ev(S + 30, 1'b0, 3'b000, 10);
        drive_at(S, B_START);
        chk("run_state", 32'(bus.state), 1);
        chk("run_move", 32'(bus.move), 0);
        drive_at(S + 3, B_LEFT);

        // Up then down inside one interval: the later press wins.
        expect_ev(S + 40, 1'b0, 3'b011, 10);
        drive_at(S + 32, B_UP);
        drive_at(S + 34, B_DOWN);
        // Up+left together: up wins priority but reverses down, so nothing changes.
        expect_ev(S + 50, 1'b0, 3'b011, 10);
        drive_at(S + 43, B_UP | B_LEFT);
        // Left+right together: left wins priority and is legal.
        expect_ev(S + 60, 1'b0, 3'b010, 10);
        drive_at(S + 53, B_LEFT | B_RIGHT);

        // Pause at count 6; presses while paused are ignored.
        P = S + 67;
        drive_at(P, B_START);
        chk("pause_state", 32'(bus.state), 2);
        chk("pause_move", 32'(bus.move), 32'h4);
        drive_at(P + 5, B_UP);
        wait_cyc(P + 10);
        chk("pause_hold_state", 32'(bus.state), 2);
        chk("pause_hold_move", 32'(bus.move), 32'h4);
        R = P + 21;
        expect_ev(R + 4, 1'b0, 3'b010, 10);
        drive_at(R, B_START);
        chk("resume_state", 32'(bus.state), 1);
        chk("resume_move", 32'(bus.move), 32'h2);

        // Apples: 10 -> 7 -> 4 -> 4; the second lands with counter past the new limit.
        expect_ev(R + 11, 1'b0, 3'b010, 7);
        expect_ev(R + 17, 1'b0, 3'b010, 4);
        expect_ev(R + 21, 1'b0, 3'b010, 4);
        expect_ev(R + 25, 1'b0, 3'b010, 4);
        expect_ev(R + 29, 1'b0, 3'b010, 4);
        drive_at(R + 5, B_APPLE);
        chk("apple1_period", bus.period, 7);
        drive_at(R + 16, B_APPLE);
        chk("apple2_period", bus.period, 4);
        drive_at(R + 19, B_APPLE);
        chk("apple3_period", bus.period, 4);

        // game_over on the step edge suppresses the step.
        O = R + 33;
        wait_cyc(O - 1);
        bus.game_over = 1'b1;
        @(negedge clk);
        bus.game_over = 1'b0;
        chk("over_state", 32'(bus.state), 3);
        chk("over_move", 32'(bus.move), 32'h4);
        chk("over_animate", 32'(bus.animate), 0);
        drive_at(O + 2, B_START);
        chk("over_early_start", 32'(bus.state), 3);
        drive_at(O + 6, B_START);
        chk("over_to_idle", 32'(bus.state), 0);

        // Restart restores the start period; abort it with reset at counter 7.
        S2 = cyc + 1;
        expect_ev(S2, 1'b1, 3'b000, 10);
        drive_at(S2, B_START);
        chk("restart_state", 32'(bus.state), 1);
        chk("restart_period", bus.period, 10);
        wait_cyc(S2 + 7);
        rst = 1'b0;
        #1;
        chk("abort_state", 32'(bus.state), 0);
        chk("abort_move", 32'(bus.move), 32'h4);
        chk("abort_period", bus.period, 10);
        chk("abort_animate", 32'(bus.animate), 0);
        chk("abort_game_rst", 32'(bus.game_rst), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_abort_state", 32'(bus.state), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
